// File: rtl/hazard_controller_pkg.sv
// Shared constants for the pipeline hazard controller: FSM encoding,
// the hard-wired zero register and the NOP word used by the IF/ID flush path.
package hazard_controller_pkg;

    localparam logic        RUN      = 1'b0;
    localparam logic        STALL    = 1'b1;
    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    // Load-use check between the ID source registers and the EX load target.
    function automatic logic load_use_hazard(
        input logic       mem_read_ex,
        input logic [4:0] reg_dest_ex,
        input logic       uses_rs,
        input logic [4:0] rs,
        input logic       uses_rt,
        input logic [4:0] rt
    );
        return mem_read_ex && (reg_dest_ex != REG_ZERO) &&
               ((uses_rs && (rs == reg_dest_ex)) || (uses_rt && (rt == reg_dest_ex)));
    endfunction

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Load-use stall and taken-redirect flush control for the 5-stage pipeline.
// Control outputs are combinational from the current state and inputs.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       Rs_ID,
    input  logic [4:0]       Rt_ID,
    input  logic             UsesRs_ID,
    input  logic             UsesRt_ID,
    input  logic             MemRead_EX,
    input  logic [4:0]       RegDest_EX,
    input  logic             Branch_output,
    input  logic             Jr_MEM,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             EXMEMFlush,
    output logic             Stall,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
    output logic             state_dbg
);

    localparam logic [3:0] REM_INIT = 4'(LOAD_STALL_CYCLES - 1);

    logic       state, next_state;
    logic [3:0] rem, next_rem;
    logic       haz, redir;
    logic       stall_inc, flush_inc;

    assign haz       = load_use_hazard(MemRead_EX, RegDest_EX, UsesRs_ID, Rs_ID, UsesRt_ID, Rt_ID);
    assign redir     = Branch_output | Jr_MEM;
    assign state_dbg = state;

    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        EXMEMFlush = 1'b0;
        Stall      = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        next_state = state;
        next_rem   = rem;
        if (Rst) begin
            next_state = RUN;
            next_rem   = 4'd0;
        end else if (redir) begin
            // A redirect discards the wrong path, including any pending stall.
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
            flush_inc  = 1'b1;
            next_state = RUN;
            next_rem   = 4'd0;
        end else if ((state == STALL) || haz) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
            Stall     = 1'b1;
            stall_inc = 1'b1;
            if (state == RUN) begin
                if (LOAD_STALL_CYCLES > 1) begin
                    next_state = STALL;
                    next_rem   = REM_INIT;
                end
            end else if (rem == 4'd1) begin
                next_state = RUN;
                next_rem   = 4'd0;
            end else begin
                next_rem = rem - 4'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= RUN;
            rem   <= 4'd0;
        end else begin
            state <= next_state;
            rem   <= next_rem;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .inc   (stall_inc),
        .count (StallCount)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .inc   (flush_inc),
        .count (FlushCount)
    );

endmodule
